// File: rtl/branch_predictor_pkg.sv
// Shared types and index/tag helpers for the BTB/BHT branch predictor.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_state_e;

    // Control bits of one table entry; tag and target live in separate arrays
    // because their widths are set by module parameters and they are never reset.
    typedef struct packed {
        logic       valid;
        cnt_state_e cnt;
        logic       jump;
    } bp_entry_t;

    function automatic logic [63:0] bp_index(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int idx_w,
                                           input int tag_w);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_counter.sv
// Next-state logic of the 2-bit saturating taken/not-taken counter.
module bp_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    // NOTE: assign every combinational output a default first so no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        if (taken && cnt != CNT_ST) begin
            cnt_next = cnt + 2'd1;
        end else if (!taken && cnt != CNT_SNT) begin
            cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB/BHT with zero-latency lookup, execute-stage update and
// mispredict detection with a saturating mispredict counter.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pcf,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_is_jal,
    input  logic             upd_is_jalr,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    bp_entry_t        meta_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];

    logic [IDX_W-1:0] idx_f, idx_u;
    logic [TAG_W-1:0] tag_f, tag_u;
    bp_entry_t        entry_f, entry_u, wr_entry;
    logic             hit_f, hit_u, we_meta, we_tgt;
    logic [1:0]       cnt_next;
    logic [XLEN-1:0]  actual_next, predicted_next;

    assign idx_f = IDX_W'(bp_index(64'(pcf), IDX_W));
    assign tag_f = TAG_W'(bp_tag(64'(pcf), IDX_W, TAG_W));
    assign idx_u = IDX_W'(bp_index(64'(upd_pc), IDX_W));
    assign tag_u = TAG_W'(bp_tag(64'(upd_pc), IDX_W, TAG_W));

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign entry_f     = meta_q[idx_f];
    assign hit_f       = entry_f.valid && (tag_q[idx_f] == tag_f);
    assign pred_taken  = !rst && hit_f && (entry_f.jump || entry_f.cnt inside {CNT_WT, CNT_ST});
    assign pred_target = pred_taken ? target_q[idx_f] : pcf + PC_STEP;

    assign entry_u = meta_q[idx_u];
    assign hit_u   = entry_u.valid && (tag_q[idx_u] == tag_u);

    bp_counter u_counter (
        .cnt      (entry_u.cnt),
        .taken    (upd_taken),
        .cnt_next (cnt_next)
    );

    always_comb begin
        we_meta  = 1'b0;
        we_tgt   = 1'b0;
        wr_entry = entry_u;
        if (upd_valid) begin
            if (upd_is_jal) begin
                we_meta  = 1'b1;
                we_tgt   = 1'b1;
                wr_entry = '{valid: 1'b1, cnt: CNT_ST, jump: 1'b1};
            end else if (upd_is_jalr) begin
                we_meta        = hit_u;
                wr_entry.valid = 1'b0;
            end else if (hit_u) begin
                we_meta      = 1'b1;
                we_tgt       = upd_taken;
                wr_entry.cnt = cnt_state_e'(cnt_next);
            end else if (upd_taken) begin
                we_meta  = 1'b1;
                we_tgt   = 1'b1;
                wr_entry = '{valid: 1'b1, cnt: CNT_WT, jump: 1'b0};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta_q[i] <= '0;
            end
        end else if (we_meta) begin
            meta_q[idx_u] <= wr_entry;
        end
    end

    // NOTE: tag/target storage has no reset; the cleared valid bit already masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && we_tgt) begin
            tag_q[idx_u]    <= tag_u;
            target_q[idx_u] <= upd_target;
        end
    end

    assign actual_next    = upd_taken ? upd_target : upd_pc + PC_STEP;
    assign predicted_next = upd_pred_taken ? upd_pred_target : upd_pc + PC_STEP;
    assign mispredict     = !rst && upd_valid && (actual_next != predicted_next);
    assign redirect_pc    = actual_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_cnt <= '0;
        end else if (mispredict && mispred_cnt != '1) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor (64 entries, 8-bit tag, 2-bit mispredict counter).
module tb_branch_predictor;

    localparam int XLEN = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [XLEN-1:0]  pcf;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_is_jal;
    logic             upd_is_jalr;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_target;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] mispred_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    branch_predictor #(.XLEN(XLEN), .ENTRIES(64), .TAG_W(8), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .pcf             (pcf),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_is_jal      (upd_is_jal),
        .upd_is_jalr     (upd_is_jalr),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .mispred_cnt     (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // kind: 0 branch, 1 jal, 2 jalr
    task automatic upd(input logic v, input logic [31:0] pc, input int kind, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        upd_valid       = v;
        upd_pc          = pc;
        upd_is_jal      = (kind == 1);
        upd_is_jalr     = (kind == 2);
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    task automatic idle();
        upd(1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Advance one clock; stimulus changes 1 time unit after the edge, checks 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pcf = 32'h100;
        upd(1'b1, 32'h100, 0, 1'b1, 32'h80, 1'b0, 32'h0);
        #2;
        check("rst_pred_taken", pred_taken, 0);
        check("rst_pred_target", pred_target, 32'h104);
        check("rst_mispredict", mispredict, 0);
        tick();

        rst = 1'b0;
        idle();
        #2;
        check("post_rst_pred_taken", pred_taken, 0);
        check("post_rst_pred_target", pred_target, 32'h104);
        check("post_rst_cnt", mispred_cnt, 0);
        tick();

        // Taken branch 0x100 -> 0x80, predicted not-taken; lookup same cycle sees old state
        upd(1'b1, 32'h100, 0, 1'b1, 32'h80, 1'b0, 32'h0);
        #2;
        check("alloc_mispredict", mispredict, 1);
        check("alloc_redirect", redirect_pc, 32'h80);
        check("same_cycle_old_state", pred_taken, 0);
        tick();

        // Counter 10: predicts taken; resolve not-taken with pred taken -> mispredict
        upd(1'b1, 32'h100, 0, 1'b0, 32'h0, 1'b1, 32'h80);
        #2;
        check("hit_pred_taken", pred_taken, 1);
        check("hit_pred_target", pred_target, 32'h80);
        check("nt1_mispredict", mispredict, 1);
        check("nt1_redirect", redirect_pc, 32'h104);
        check("cnt_after_1", mispred_cnt, 1);
        tick();

        // Counter 01: predicts not-taken; second not-taken matches prediction
        upd(1'b1, 32'h100, 0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        check("wnt_pred_taken", pred_taken, 0);
        check("wnt_pred_target", pred_target, 32'h104);
        check("nt2_mispredict", mispredict, 0);
        check("cnt_after_2", mispred_cnt, 2);
        tick();

        // JAL 0x200 -> 0x400 (index 0, tag 2)
        pcf = 32'h100;
        upd(1'b1, 32'h200, 1, 1'b1, 32'h400, 1'b0, 32'h0);
        #2;
        check("snt_pred_taken", pred_taken, 0);
        check("jal_mispredict", mispredict, 1);
        check("jal_redirect", redirect_pc, 32'h400);
        tick();

        // Five not-taken branches at 0x300 alias index 0 with tag 3
        pcf = 32'h200;
        for (int k = 0; k < 5; k++) begin
            upd(1'b1, 32'h300, 0, 1'b0, 32'h0, 1'b0, 32'h0);
            #2;
            check("alias_jal_pred_taken", pred_taken, 1);
            check("alias_jal_pred_target", pred_target, 32'h400);
            check("alias_mispredict", mispredict, 0);
            tick();
        end

        pcf = 32'h300;
        upd(1'b1, 32'h600, 0, 1'b0, 32'h0, 1'b1, 32'h999);
        #2;
        check("alias_miss_taken", pred_taken, 0);
        check("alias_miss_target", pred_target, 32'h304);
        check("cnt_after_3", mispred_cnt, 3);
        check("nt_miss_mispredict", mispredict, 1);
        check("nt_miss_redirect", redirect_pc, 32'h604);
        tick();

        pcf = 32'h200;
        upd(1'b1, 32'h600, 0, 1'b0, 32'h0, 1'b1, 32'h999);
        #2;
        check("jal_still_taken", pred_taken, 1);
        check("jal_still_target", pred_target, 32'h400);
        check("cnt_sat_hold", mispred_cnt, 3);
        tick();

        // JALR hit at 0x200 invalidates the entry; prediction was correct
        upd(1'b1, 32'h200, 2, 1'b1, 32'h400, 1'b1, 32'h400);
        #2;
        check("cnt_saturated", mispred_cnt, 3);
        check("jalr_mispredict", mispredict, 0);
        tick();

        pcf = 32'h200;
        upd(1'b1, 32'h100, 1, 1'b1, 32'h40, 1'b1, 32'h40);
        #2;
        check("jalr_cleared_taken", pred_taken, 0);
        check("jalr_cleared_target", pred_target, 32'h204);
        check("jal_correct_mispredict", mispredict, 0);
        pcf = 32'hFFFF_FFFC;
        #1;
        check("wrap_pred_target", pred_target, 32'h0);
        tick();

        pcf = 32'h100;
        upd(1'b1, 32'hFFFF_FFFC, 0, 1'b0, 32'h0, 1'b1, 32'h10);
        #2;
        check("jal2_pred_taken", pred_taken, 1);
        check("jal2_pred_target", pred_target, 32'h40);
        check("wrap_mispredict", mispredict, 1);
        check("wrap_redirect", redirect_pc, 32'h0);
        tick();

        // Reset mid-stream with a conflicting update that must be dropped
        rst = 1'b1;
        upd(1'b1, 32'h700, 0, 1'b1, 32'h20, 1'b0, 32'h0);
        #2;
        check("rst2_pred_taken", pred_taken, 0);
        check("rst2_pred_target", pred_target, 32'h104);
        check("rst2_mispredict", mispredict, 0);
        tick();

        rst = 1'b0;
        idle();
        #2;
        check("rst2_cnt", mispred_cnt, 0);
        check("rst2_miss_100", pred_taken, 0);
        pcf = 32'h700;
        #1;
        check("rst2_dropped_700", pred_taken, 0);
        tick();
        #2;
        check("rst2_miss_700_later", pred_taken, 0);
        check("rst2_cnt_hold", mispred_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width.
REQ-002 Parameter ENTRIES, default 64, BTB/BHT depth; SHALL be a power of two, at least 4.
REQ-003 Parameter TAG_W, default 8, stored tag width.
REQ-004 Parameter CNT_W, default 16, mispredict performance counter width.
REQ-005 clk  in  1  sole clock; rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pcf  in  XLEN  fetch-stage PC for lookup.
REQ-008 pred_taken  out  1  fetch redirect predicted.
REQ-009 pred_target  out  XLEN  predicted next PC; equals pcf+4 when pred_taken=0.
REQ-010 upd_valid  in  1  execute-stage control-flow instruction resolved this cycle.
REQ-011 upd_pc  in  XLEN  PC of the resolving instruction.
REQ-012 upd_is_jal, upd_is_jalr  in  1 each  instruction kind; both 0 means conditional branch.
REQ-013 upd_taken  in  1  actual outcome.
REQ-014 upd_target  in  XLEN  actual taken target.
REQ-015 upd_pred_taken, upd_pred_target  in  1, XLEN  prediction carried down the pipe with the instruction.
REQ-016 mispredict  out  1  execute-stage redirect required.
REQ-017 redirect_pc  out  XLEN  correct next PC when mispredict=1.
REQ-018 mispred_cnt  out  CNT_W  saturating mispredict count.

Function
- REQ-019 Index = pc[log2(ENTRIES)+1:2]; tag = next TAG_W bits above the index.
- REQ-020 Each entry holds: valid, tag, XLEN target, 2-bit counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T), jump flag.
- REQ-021 Lookup is combinational, zero latency: hit = valid and tag match; pred_taken = hit and (jump flag or counter[1]).
- REQ-022 Update is written at the rising edge when upd_valid=1; the written value is visible to lookup from the next cycle.
- REQ-023 A lookup and an update to the same index in the same cycle: the lookup returns the pre-update contents (no bypass).
- REQ-024 Branch, hit: counter saturates up on taken and down on not-taken; target is overwritten by upd_target on taken.
- REQ-025 Branch, miss, taken: allocate the entry with counter=10, jump=0. Branch, miss, not-taken: no write.
- REQ-026 JAL: allocate or overwrite the entry with counter=11, jump=1, target=upd_target.
- REQ-027 JALR: if hit, clear valid; never allocate.
- REQ-028 Actual next PC = upd_taken ? upd_target : upd_pc+4; predicted next PC = upd_pred_taken ? upd_pred_target : upd_pc+4.
- REQ-029 mispredict = upd_valid and (actual next PC differs from predicted next PC). This output is combinational. redirect_pc = actual next PC.
- REQ-030 mispred_cnt increments by 1 on each cycle with mispredict=1 and holds at all-ones.
- REQ-031 All arithmetic is modulo 2^XLEN; pc+4 wraps.

Reset
- REQ-032 While rst=1, all valid bits and all counters clear at the clock edge, mispred_cnt goes to 0, and any update in that cycle is dropped.
- REQ-033 During the rst=1 cycle, pred_taken=0, pred_target=pcf+4, and mispredict=0.
- REQ-034 Target and tag storage needs no reset.

Structure
- REQ-035 A shared package holds the counter-state enum, the entry struct, and the index/tag helper functions.
- REQ-036 One sub-module, bp_counter: the 2-bit saturating counter next-state logic.
- REQ-037 The table is a register array with a single write port; mispredict/redirect logic is in the top level.

Verification
- REQ-038 Reset, then pcf=0x100 -> pred_taken=0, pred_target=0x104.
- REQ-039 Taken branch at 0x100 to 0x80 -> next cycle pcf=0x100 gives pred_taken=1, pred_target=0x80; mispredict was 1 with redirect_pc=0x80.
- REQ-040 Same branch resolved not-taken twice -> counter goes 10->01->00, pred_taken=0; first resolution flags mispredict with redirect_pc=0x104.
- REQ-041 JAL at 0x200 to 0x400, then five not-taken branch updates aliasing index 0x200 with a different tag -> no allocation occurs; 0x200 still predicts 0x400.
- REQ-042 Lookup and update on the same index in the same cycle -> lookup shows old state; new state appears the next cycle.
- REQ-043 CNT_W=2 with 5 mispredicts -> mispred_cnt=3; assert rst mid-stream -> count=0 and all entries miss.
